// File: rtl/alu_exec_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_exec_if : operand/handshake/result bundle for alu_exec_unit       |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
interface alu_exec_if #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
) ();
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  srcA;
    logic [WIDTH-1:0]  srcB;
    logic [IMM_W-1:0]  imm;
    logic [1:0]        aluop;
    logic              alusrc;
    logic [WIDTH-1:0]  result;
    logic              zero;
    logic              out_valid;
    logic              busy;
    logic              md_done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    modport slave (
        input  in_valid, srcA, srcB, imm, aluop, alusrc,
        output in_ready, result, zero, out_valid, busy, md_done, hi, lo
    );

    modport master (
        output in_valid, srcA, srcB, imm, aluop, alusrc,
        input  in_ready, result, zero, out_valid, busy, md_done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_exec_unit : registered execute stage with iterative mult/div      |
// | Revision      : 1.0                                                   |
// +-----------------------------------------------------------------------+
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    alu_exec_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q, hi_q, lo_q;
    logic               zero_q, out_valid_q, md_done_q;
    logic [WIDTH-1:0]   acc_hi_q, acc_lo_q, opb_q, a_q;
    logic               div_q, neg_q, rneg_q, divz_q;

    logic [5:0]         w_funct;
    logic [WIDTH-1:0]   w_opb, w_a_mag, w_b_mag, result_d;
    logic               w_accept, w_is_md, w_a_neg, w_b_neg, w_slt;

    assign w_funct  = bus.imm[5:0];
    assign w_opb    = bus.alusrc ? {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm} : bus.srcB;
    assign w_accept = bus.in_valid && (state_q == S_IDLE);
    assign w_is_md  = (bus.aluop == 2'b10) && (w_funct[5:2] == 4'b0110);
    assign w_slt    = $signed(bus.srcA) < $signed(w_opb);

    // funct[0]=1 selects the unsigned variant of mult/div
    assign w_a_neg  = !w_funct[0] && bus.srcA[WIDTH-1];
    assign w_b_neg  = !w_funct[0] && bus.srcB[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.srcA : bus.srcA;
    assign w_b_mag  = w_b_neg ? -bus.srcB : bus.srcB;

    always_comb begin
        result_d = '0;
        case (bus.aluop)
            2'b00: result_d = bus.srcA + w_opb;
            2'b01: result_d = bus.srcA - w_opb;
            2'b11: result_d = {{(WIDTH-1){1'b0}}, w_slt};
            default: begin
                case (w_funct)
                    6'b100000: result_d = bus.srcA + w_opb;
                    6'b100010: result_d = bus.srcA - w_opb;
                    6'b100100: result_d = bus.srcA & w_opb;
                    6'b100101: result_d = bus.srcA | w_opb;
                    6'b101010: result_d = {{(WIDTH-1){1'b0}}, w_slt};
                    6'b010000: result_d = hi_q;
                    6'b010010: result_d = lo_q;
                    default:   result_d = '0;
                endcase
            end
        endcase
    end

    // Shared iteration datapath: multiply shifts right, divide shifts left
    logic [WIDTH:0]     w_sum, w_shift;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0]   w_hi_d, w_lo_d;

    assign w_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    assign w_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign w_ge    = w_shift >= {1'b0, opb_q};
    assign w_diff  = w_shift[WIDTH-1:0] - opb_q;
    assign w_prod  = {acc_hi_q, acc_lo_q};
    assign w_prod_fix = neg_q ? -w_prod : w_prod;

    always_comb begin
        w_hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
        w_lo_d = w_prod_fix[WIDTH-1:0];
        if (div_q) begin
            if (divz_q) begin
                w_hi_d = a_q;
                w_lo_d = '1;
            end else begin
                w_hi_d = rneg_q ? -acc_hi_q : acc_hi_q;
                w_lo_d = neg_q  ? -acc_lo_q : acc_lo_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            md_done_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            opb_q       <= '0;
            a_q         <= '0;
            div_q       <= 1'b0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            divz_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            md_done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_accept && w_is_md) begin
                        state_q  <= S_RUN;
                        cnt_q    <= '0;
                        acc_hi_q <= '0;
                        acc_lo_q <= w_a_mag;
                        opb_q    <= w_b_mag;
                        a_q      <= bus.srcA;
                        div_q    <= w_funct[1];
                        neg_q    <= w_a_neg ^ w_b_neg;
                        rneg_q   <= w_a_neg;
                        divz_q   <= (bus.srcB == '0);
                    end else if (w_accept) begin
                        result_q    <= result_d;
                        zero_q      <= (result_d == '0);
                        out_valid_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (div_q) begin
                        acc_hi_q <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                        acc_lo_q <= {acc_lo_q[WIDTH-2:0], w_ge};
                    end else begin
                        acc_hi_q <= w_sum[WIDTH:1];
                        acc_lo_q <= {w_sum[0], acc_lo_q[WIDTH-1:1]};
                    end
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        cnt_q   <= '0;
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FIX: begin
                    hi_q      <= w_hi_d;
                    lo_q      <= w_lo_d;
                    md_done_q <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = out_valid_q;
    assign bus.md_done   = md_done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_alu_exec_unit : directed vector bench for alu_exec_unit (W=32)     |
// | Revision         : 1.0                                                |
// +-----------------------------------------------------------------------+
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    alu_exec_if #(.WIDTH(32), .IMM_W(16)) bus ();
    alu_exec_unit #(.WIDTH(32), .IMM_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
        logic [1:0]  aluop;
        logic        alusrc;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                         input logic [1:0] op, input logic src);
        bus.in_valid = 1'b1;
        bus.srcA     = a;
        bus.srcB     = b;
        bus.imm      = imm;
        bus.aluop    = op;
        bus.alusrc   = src;
    endtask

    task automatic run_md(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] f, input logic [31:0] eh, input logic [31:0] el);
        logic [31:0] res_before;
        int bad;
        res_before = bus.result;
        bad = 0;
        drive(a, b, {10'd0, f}, 2'b10, 1'b1);
        step();
        bus.in_valid = 1'b0;
        bus.srcA     = 32'h1234_5678;
        bus.srcB     = 32'h9ABC_DEF0;
        for (int i = 0; i <= 32; i++) begin
            if (i > 0) step();
            if (!bus.busy || bus.in_ready || bus.md_done || bus.out_valid) bad++;
        end
        chk({name, " busy window violations"}, bad, 0);
        step();
        chk({name, " md_done"}, bus.md_done, 1);
        chk({name, " busy after"}, bus.busy, 0);
        chk({name, " hi"}, bus.hi, eh);
        chk({name, " lo"}, bus.lo, el);
        chk({name, " result held"}, bus.result, res_before);
        step();
        chk({name, " md_done drop"}, bus.md_done, 0);
    endtask

    initial begin
        vecs[0]  = '{32'd5,        32'd7,        16'h0000, 2'b00, 1'b0, 32'd12,        1'b0};
        vecs[1]  = '{32'd3,        32'd99,       16'h0003, 2'b01, 1'b1, 32'd0,         1'b1};
        vecs[2]  = '{32'd3,        32'd99,       16'hFFFF, 2'b00, 1'b1, 32'd2,         1'b0};
        vecs[3]  = '{32'h0000F0F0, 32'h00000FF0, 16'h0024, 2'b10, 1'b0, 32'h000000F0,  1'b0};
        vecs[4]  = '{32'h0000F000, 32'h0000000F, 16'h0025, 2'b10, 1'b0, 32'h0000F00F,  1'b0};
        vecs[5]  = '{32'hFFFFFFFF, 32'd1,        16'h002A, 2'b10, 1'b0, 32'd1,         1'b0};
        vecs[6]  = '{32'd1,        32'hFFFFFFFF, 16'h002A, 2'b10, 1'b0, 32'd0,         1'b1};
        vecs[7]  = '{32'hFFFFFFFB, 32'd3,        16'h0000, 2'b11, 1'b0, 32'd1,         1'b0};
        vecs[8]  = '{32'hFFFFFFFF, 32'd1,        16'h0020, 2'b10, 1'b0, 32'd0,         1'b1};
        vecs[9]  = '{32'd0,        32'd1,        16'h0022, 2'b10, 1'b0, 32'hFFFFFFFF,  1'b0};
        vecs[10] = '{32'd9,        32'd9,        16'h003F, 2'b10, 1'b0, 32'd0,         1'b1};
        vecs[11] = '{32'd1,        32'd500,      16'h0020, 2'b10, 1'b1, 32'h00000021,  1'b0};
        vecs[12] = '{32'd0,        32'd500,      16'hFFFF, 2'b11, 1'b1, 32'd0,         1'b1};

        drive(32'd0, 32'd0, 16'd0, 2'b00, 1'b0);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        step();
        step();
        chk("reset result", bus.result, 0);
        chk("reset zero", bus.zero, 0);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset md_done", bus.md_done, 0);
        chk("reset hi", bus.hi, 0);
        chk("reset lo", bus.lo, 0);
        reset = 1'b0;

        // Back-to-back single-cycle ops, one per cycle
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].aluop, vecs[i].alusrc);
            step();
            chk($sformatf("vec%0d result", i), bus.result, vecs[i].exp_res);
            chk($sformatf("vec%0d zero", i), bus.zero, vecs[i].exp_zero);
            chk($sformatf("vec%0d out_valid", i), bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("idle out_valid", bus.out_valid, 0);
        chk("idle result held", bus.result, 0);

        run_md("mult", 32'hFFFFFFFD, 32'd7, 6'b011000, 32'hFFFFFFFF, 32'hFFFFFFEB);
        drive(32'd0, 32'd0, 16'h0012, 2'b10, 1'b0);
        step();
        chk("mflo result", bus.result, 32'hFFFFFFEB);
        drive(32'd0, 32'd0, 16'h0010, 2'b10, 1'b0);
        step();
        chk("mfhi result", bus.result, 32'hFFFFFFFF);
        bus.in_valid = 1'b0;
        step();

        run_md("multu", 32'hFFFFFFFF, 32'hFFFFFFFF, 6'b011001, 32'hFFFFFFFE, 32'h00000001);
        run_md("div -7/2", 32'hFFFFFFF9, 32'd2, 6'b011010, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("divu 7/0", 32'd7, 32'd0, 6'b011011, 32'd7, 32'hFFFFFFFF);
        run_md("div min/-1", 32'h80000000, 32'hFFFFFFFF, 6'b011010, 32'd0, 32'h80000000);
        run_md("div -7/0", 32'hFFFFFFF9, 32'd0, 6'b011010, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_md("divu 100/7", 32'd100, 32'd7, 6'b011011, 32'd2, 32'd14);

        // Reset in the middle of a multu discards it
        drive(32'd5, 32'd6, 16'h0019, 2'b10, 1'b0);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        drive(32'd1, 32'd1, 16'h0000, 2'b00, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset busy", bus.busy, 0);
        chk("midreset hi", bus.hi, 0);
        chk("midreset lo", bus.lo, 0);
        chk("midreset out_valid", bus.out_valid, 0);
        drive(32'd4, 32'd5, 16'h0000, 2'b00, 1'b0);
        step();
        chk("post-reset add result", bus.result, 32'd9);
        chk("post-reset add out_valid", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (bus.md_done) pulses++;
            end
            chk("midreset md_done pulses", pulses, 0);
        end

        // Reset wins over a simultaneous accept while idle
        drive(32'd2, 32'd2, 16'h0000, 2'b00, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        chk("reset prio out_valid", bus.out_valid, 0);
        chk("reset prio result", bus.result, 0);

        // in_valid held while busy: the add is taken on the md_done cycle
        begin
            int bad;
            bad = 0;
            drive(32'd2, 32'd3, 16'h0018, 2'b10, 1'b0);
            step();
            drive(32'd10, 32'd20, 16'h0000, 2'b00, 1'b0);
            for (int i = 0; i <= 33; i++) begin
                if (i > 0) step();
                if (bus.out_valid || (bus.md_done != (i == 33))) bad++;
            end
            chk("held in_valid stall violations", bad, 0);
            step();
            bus.in_valid = 1'b0;
            chk("held add out_valid", bus.out_valid, 1);
            chk("held add result", bus.result, 32'd30);
            chk("held mult lo", bus.lo, 32'd6);
            chk("held mult hi", bus.hi, 32'd0);
            step();
            chk("held add single pulse", bus.out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
